// File: rtl/dvp_tx_pkg.sv
// dvp_pkg: shared FSM states, RGB565 colours and default
// timing for the DVP transmitter slice.
package dvp_pkg;

  localparam int H_ACTIVE_D  = 1024;
  localparam int V_ACTIVE_D  = 768;
  localparam int H_BLANK_D   = 256;
  localparam int VS_LINES_D  = 4;
  localparam int VBP_LINES_D = 16;
  localparam int VFP_LINES_D = 8;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_VSYNC  = 3'd1;
  localparam state_t S_VBP    = 3'd2;
  localparam state_t S_ACTIVE = 3'd3;
  localparam state_t S_BLANK  = 3'd4;
  localparam state_t S_VFP    = 3'd5;
  localparam state_t S_DONE   = 3'd6;

  localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
  localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
  localparam logic [15:0] RGB_CYAN    = 16'h07FF;
  localparam logic [15:0] RGB_GREEN   = 16'h07E0;
  localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
  localparam logic [15:0] RGB_RED     = 16'hF800;
  localparam logic [15:0] RGB_BLUE    = 16'h001F;
  localparam logic [15:0] RGB_BLACK   = 16'h0000;

  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dvp_tx_if.sv
// dvp_tx_if: pixel FIFO side and DVP byte side of the
// transmitter; master is the transmitter.
interface dvp_tx_if;

  logic        pix_rd_en;
  logic [15:0] pix_data;
  logic        pix_empty;
  logic        dvp_vsync;
  logic        dvp_href;
  logic [7:0]  dvp_data;

  modport master (
    output pix_rd_en,
    input  pix_data,
    input  pix_empty,
    output dvp_vsync,
    output dvp_href,
    output dvp_data
  );

  modport slave (
    input  pix_rd_en,
    output pix_data,
    output pix_empty,
    input  dvp_vsync,
    input  dvp_href,
    input  dvp_data
  );

endinterface

// File: rtl/dvp_tx_pattern.sv
// dvp_tx_pattern: 8-bar RGB565 colour lookup by pixel
// index within a line (used with DVP_TX_TEST_PATTERN_EN).
module dvp_tx_pattern
  import dvp_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_D,
  parameter int IW       = 12
) (
  input  logic [IW-1:0] pix_idx,
  output logic [15:0]   pix
);

  logic [2:0] bar;

  assign bar = 3'((32'(pix_idx) * 8) / H_ACTIVE);

  // bar index to colour
  always_comb begin
    pix = RGB_BLACK;
    unique case (bar)
      3'd0: pix = RGB_WHITE;
      3'd1: pix = RGB_YELLOW;
      3'd2: pix = RGB_CYAN;
      3'd3: pix = RGB_GREEN;
      3'd4: pix = RGB_MAGENTA;
      3'd5: pix = RGB_RED;
      3'd6: pix = RGB_BLUE;
      3'd7: pix = RGB_BLACK;
      default: pix = RGB_BLACK;
    endcase
  end

endmodule

// File: rtl/dvp_tx.sv
// dvp_tx: 8-bit DVP transmitter, RGB565 FIFO in, href/vsync out.
// `define DVP_TX_TEST_PATTERN_EN adds test_mode and colour bars.
module dvp_tx
  import dvp_pkg::*;
#(
  parameter int H_ACTIVE  = H_ACTIVE_D,
  parameter int V_ACTIVE  = V_ACTIVE_D,
  parameter int H_BLANK   = H_BLANK_D,
  parameter int VS_LINES  = VS_LINES_D,
  parameter int VBP_LINES = VBP_LINES_D,
  parameter int VFP_LINES = VFP_LINES_D
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      start,
`ifdef DVP_TX_TEST_PATTERN_EN
  input  logic      test_mode,
`endif
  dvp_tx_if.master  bus,
  output logic      busy,
  output logic      frame_done,
  output logic      underflow
);

  localparam int L    = 2 * H_ACTIVE + H_BLANK;
  localparam int HW   = cw(L);
  localparam int VMAX = max2(max2(VS_LINES, VBP_LINES),
                             max2(V_ACTIVE, VFP_LINES));
  localparam int VW   = cw(VMAX);

  localparam logic [HW-1:0] H_END  = HW'(L - 1);
  localparam logic [HW-1:0] H_PRE  = HW'(L - 2);
  localparam logic [HW-1:0] H_AEND = HW'(2 * H_ACTIVE - 1);
  localparam logic [HW-1:0] H_RLIM = HW'(2 * H_ACTIVE - 2);

  localparam logic [VW-1:0] VS_END  = VW'(VS_LINES - 1);
  localparam logic [VW-1:0] VBP_END = VW'(VBP_LINES - 1);
  localparam logic [VW-1:0] VA_END  = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] VFP_END = VW'(VFP_LINES - 1);

  state_t        state;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          v_last;
  logic          line_end;
  logic          counting;
  logic          go;
  logic          rd_slot;
  logic          slot_q;
  logic          fire_q;
  logic          pat_q;
  logic [15:0]   pix_q;
  logic          use_pat;
  logic [15:0]   pat_px;
  logic          href;

  assign line_end = (h_cnt == H_END);
  assign counting = (state != S_IDLE) && (state != S_DONE);
  assign go       = (state == S_IDLE) && start;

`ifdef DVP_TX_TEST_PATTERN_EN
  logic [HW-1:0] pat_idx;

  // slot_q sits one clk before the pixel's high byte
  assign pat_idx = line_end ? '0 : ((h_cnt + HW'(1)) >> 1);
  assign use_pat = test_mode;

  dvp_tx_pattern #(
    .H_ACTIVE (H_ACTIVE),
    .IW       (HW)
  ) u_pattern (
    .pix_idx (pat_idx),
    .pix     (pat_px)
  );
`else
  assign use_pat = 1'b0;
  assign pat_px  = RGB_BLACK;
`endif

  // last line period of the current state
  always_comb begin
    v_last = 1'b0;
    case (state)
      S_VSYNC: v_last = (v_cnt == VS_END);
      S_VBP:   v_last = (v_cnt == VBP_END);
      S_ACTIVE,
      S_BLANK: v_last = (v_cnt == VA_END);
      S_VFP:   v_last = (v_cnt == VFP_END);
      default: v_last = 1'b0;
    endcase
  end

  // frame FSM with line (h) and line-period (v) counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      case (state)
        S_IDLE:   if (start) state <= S_VSYNC;
        S_VSYNC:  if (line_end && v_last) state <= S_VBP;
        S_VBP:    if (line_end && v_last) state <= S_ACTIVE;
        S_ACTIVE: if (h_cnt == H_AEND) state <= S_BLANK;
        S_BLANK:
          if (line_end)
            state <= v_last ? S_VFP : S_ACTIVE;
        S_VFP:    if (line_end && v_last) state <= S_DONE;
        S_DONE:   state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
      if (!counting || line_end)
        h_cnt <= '0;
      else
        h_cnt <= h_cnt + HW'(1);
      if (!counting)
        v_cnt <= '0;
      else if (line_end)
        v_cnt <= v_last ? '0 : v_cnt + VW'(1);
    end
  end

  // read slot two clks ahead of every high byte; the first
  // pixel of a line is fetched at the end of the prior period
  assign rd_slot =
    ((state == S_ACTIVE) && !h_cnt[0] && (h_cnt < H_RLIM)) ||
    ((h_cnt == H_PRE) &&
     (((state == S_VBP) && v_last) ||
      ((state == S_BLANK) && !v_last)));

  assign bus.pix_rd_en = rd_slot && !bus.pix_empty && !use_pat;

  // pixel pipeline: strobe, FIFO data, pixel register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= 1'b0;
      fire_q <= 1'b0;
      pat_q  <= 1'b0;
      pix_q  <= '0;
    end else begin
      slot_q <= rd_slot;
      fire_q <= bus.pix_rd_en;
      pat_q  <= use_pat;
      if (slot_q)
        pix_q <= pat_q  ? pat_px :
                 fire_q ? bus.pix_data : 16'h0000;
    end
  end

  // sticky underflow, cleared when a frame is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      underflow <= 1'b0;
    else if (go)
      underflow <= 1'b0;
    else if (rd_slot && bus.pix_empty && !use_pat)
      underflow <= 1'b1;
  end

  assign href          = (state == S_ACTIVE);
  assign bus.dvp_href  = href;
  assign bus.dvp_vsync = (state == S_VSYNC);
  assign bus.dvp_data  = !href   ? 8'h00 :
                         h_cnt[0] ? pix_q[7:0] : pix_q[15:8];
  assign busy          = counting;
  assign frame_done    = (state == S_DONE);

endmodule

// File: tb/tb_dvp_tx.sv
// tb_dvp_tx: directed frames with a byte scoreboard fed by
// the pixel loads; small geometry L=11, frame 55 clks.
module tb_dvp_tx;

  localparam int HA  = 4;
  localparam int VA  = 2;
  localparam int HB  = 3;
  localparam int VS  = 1;
  localparam int VBP = 1;
  localparam int VFP = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy;
  logic frame_done;
  logic underflow;

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;

  logic [15:0] fifo[$];
  logic [7:0]  exp_q[$];

  dvp_tx_if bus ();

  always #5 clk = ~clk;

  dvp_tx #(
    .H_ACTIVE  (HA),
    .V_ACTIVE  (VA),
    .H_BLANK   (HB),
    .VS_LINES  (VS),
    .VBP_LINES (VBP),
    .VFP_LINES (VFP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
`ifdef DVP_TX_TEST_PATTERN_EN
    .test_mode  (1'b0),
`endif
    .bus        (bus.master),
    .busy       (busy),
    .frame_done (frame_done),
    .underflow  (underflow)
  );

`ifdef DVP_TX_TEST_PATTERN_EN
  logic start2 = 1'b0;
  logic busy2;
  logic done2;
  logic uf2;

  dvp_tx_if bus2 ();

  dvp_tx #(
    .H_ACTIVE  (8),
    .V_ACTIVE  (VA),
    .H_BLANK   (HB),
    .VS_LINES  (VS),
    .VBP_LINES (VBP),
    .VFP_LINES (VFP)
  ) dut2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start2),
    .test_mode  (1'b1),
    .bus        (bus2.master),
    .busy       (busy2),
    .frame_done (done2),
    .underflow  (uf2)
  );
`endif

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] want);
    n_chk++;
    assert (got === want) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  task automatic push_exp(input logic [15:0] p);
    exp_q.push_back(p[15:8]);
    exp_q.push_back(p[7:0]);
  endtask

  task automatic push_px(input logic [15:0] p);
    fifo.push_back(p);
    push_exp(p);
  endtask

  // one frame from the current negedge; uf_k forces an empty
  // FIFO in that clk, poke pulses start mid-frame and in DONE
  task automatic run_frame(input int uf_k, input bit poke);
    int rd_cnt;
    int ph;
    bit rm1;
    bit rm2;
    bit eh;
    logic [4:0] sv;
    logic [4:0] sw;
    logic [7:0] eb;
    rd_cnt = 0;
    rm1 = 1'b0;
    rm2 = 1'b0;
    start = 1'b1;
    for (int k = 1; k <= 62; k++) begin
      @(negedge clk);
      start = poke && (k == 30 || k == 56);
      bus.pix_empty = (k == uf_k) || (fifo.size() == 0);
      #1;
      eh = (k >= 23 && k <= 30) || (k >= 34 && k <= 41);
      ph = (k <= 30) ? k - 23 : k - 34;
      eb = 8'h00;
      if (eh)
        eb = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hEE;
      sv = {bus.dvp_vsync, bus.dvp_href, busy,
            frame_done, underflow};
      sw = {k <= 11, eh, k <= 55, k == 56,
            uf_k > 0 && k > uf_k};
      chk($sformatf("sync k=%0d", k), 32'(sv), 32'(sw));
      chk($sformatf("data k=%0d", k),
          32'(bus.dvp_data), 32'(eb));
      if (rm2)
        chk($sformatf("rd_align k=%0d", k),
            {30'd0, bus.dvp_href, ph[0]}, 32'd2);
      rm2 = rm1;
      rm1 = bus.pix_rd_en;
      if (bus.pix_rd_en) begin
        rd_cnt++;
        bus.pix_data = (fifo.size() > 0) ?
                       fifo.pop_front() : 16'hDEAD;
      end
    end
    chk("rd_count", rd_cnt, (uf_k > 0) ? 7 : 8);
    chk("exp_left", exp_q.size(), 0);
  endtask

`ifdef DVP_TX_TEST_PATTERN_EN
  task automatic run_pattern();
    logic [7:0] pb [16];
    logic [7:0] w;
    int rds;
    pb = '{8'hFF, 8'hFF, 8'hFF, 8'hE0,
           8'h07, 8'hFF, 8'h07, 8'hE0,
           8'hF8, 8'h1F, 8'hF8, 8'h00,
           8'h00, 8'h1F, 8'h00, 8'h00};
    rds = 0;
    bus2.pix_empty = 1'b1;
    bus2.pix_data = 16'h0000;
    start2 = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      start2 = 1'b0;
      #1;
      if (bus2.pix_rd_en) rds++;
      if (k >= 39 && k <= 54) begin
        w = pb[k - 39];
        chk($sformatf("pat k=%0d", k),
            {23'd0, bus2.dvp_href, bus2.dvp_data},
            {23'd0, 1'b1, w});
      end
    end
    chk("pat_rd", rds, 0);
    chk("pat_uf", 32'(uf2), 32'd0);
  endtask
`endif

  initial begin
    bus.pix_empty = 1'b1;
    bus.pix_data = 16'h0000;
    repeat (2) @(negedge clk);
    chk("reset",
        {24'd0, bus.dvp_vsync, bus.dvp_href, busy,
         frame_done, underflow, bus.pix_rd_en,
         |bus.dvp_data, 1'b0}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    push_px(16'h1234);
    push_px(16'h5678);
    push_px(16'h9ABC);
    push_px(16'hDEF0);
    push_px(16'h1111);
    push_px(16'h2222);
    push_px(16'h3333);
    push_px(16'h4444);
    run_frame(0, 1'b0);

    fifo.push_back(16'hA1A2);
    push_exp(16'hA1A2);
    push_exp(16'h0000);
    push_px(16'hB1B2);
    push_px(16'hC1C2);
    push_px(16'hD1D2);
    push_px(16'hE1E2);
    push_px(16'hF1F2);
    push_px(16'h0102);
    run_frame(23, 1'b0);

    push_px(16'h0F0F);
    push_px(16'hF0F0);
    push_px(16'h5A5A);
    push_px(16'hA5A5);
    push_px(16'h0001);
    push_px(16'h8000);
    push_px(16'h7E7E);
    push_px(16'h8181);
    run_frame(0, 1'b1);

    bus.pix_empty = 1'b1;
    start = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #1;
    chk("pre_rst_href", 32'(bus.dvp_href), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid",
        {24'd0, bus.dvp_vsync, bus.dvp_href, busy,
         frame_done, underflow, bus.pix_rd_en,
         |bus.dvp_data, 1'b0}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    fifo.delete();
    exp_q.delete();
    @(negedge clk);
    push_px(16'hCAFE);
    push_px(16'hBEEF);
    push_px(16'h0BAD);
    push_px(16'hF00D);
    push_px(16'h1357);
    push_px(16'h2468);
    push_px(16'hACE1);
    push_px(16'hBD02);
    run_frame(0, 1'b0);

`ifdef DVP_TX_TEST_PATTERN_EN
    run_pattern();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
